// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a double-buffered value,
// per-slot ghost blanking, hex decode and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int CLK_DIV   = 5000,
  parameter int BLANK_CYC = 2,
  parameter int LZ_BLANK  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shown_q, shown_d, pend_q, pend_d;
  logic [3:0]    sdp_q, sdp_d, pdp_q, pdp_d;
  logic          pending_q, pending_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q;

  logic          tick, bnd, lz;
  logic [3:0]    nib;
  logic [15:0]   upper;
  logic [7:0]    hex_full;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    bnd       = tick && (idx_q == 2'd3);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shown_d   = shown_q;
    sdp_d     = sdp_q;
    pend_d    = pend_q;
    pdp_d     = pdp_q;
    pending_d = pending_q;
    // A load landing on the boundary itself bypasses the pend buffer.
    if (bnd) begin
      pending_d = 1'b0;
      if (load) begin
        shown_d = value;
        sdp_d   = dp;
      end else if (pending_q) begin
        shown_d = pend_q;
        sdp_d   = pdp_q;
      end
    end else if (load) begin
      pend_d    = value;
      pdp_d     = dp;
      pending_d = 1'b1;
    end

    nib      = shown_q[4*idx_q +: 4];
    upper    = shown_q >> {idx_q, 2'b00};
    lz       = (LZ_BLANK != 0) && (idx_q != 2'd0) && (upper == 16'h0000);
    hex_full = hex_seg(nib);
    seg_d    = {~sdp_q[idx_q], lz ? 7'h7F : hex_full[6:0]};
    an_d     = ~(4'b0001 << idx_q);
    if (blank || (cnt_q < BLANK_END)) begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shown_q   <= 16'h0000;
      sdp_q     <= 4'h0;
      pend_q    <= 16'h0000;
      pdp_q     <= 4'h0;
      pending_q <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shown_q   <= shown_d;
      sdp_q     <= sdp_d;
      pend_q    <= pend_d;
      pdp_q     <= pdp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= bnd;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver: two instances (with and
// without leading-zero blanking) share stimulus and are checked every cycle.
module tb_seg_scan_driver;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int FRAME = 4 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank = 1'b0;
  logic [7:0]  seg, seg_lz;
  logic [3:0]  an, an_lz;
  logic        fd, fd_lz, pend, pend_lz;

  seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC), .LZ_BLANK(0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg(seg), .an(an), .frame_done(fd), .pending(pend));

  seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg(seg_lz), .an(an_lz), .frame_done(fd_lz), .pending(pend_lz));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] seg_lz;
    logic [3:0] an;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: t counts clock edges since reset release.
  int          m_t;
  logic [15:0] m_shown, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input int t, input logic [15:0] sv,
                                           input logic [3:0] sd, input logic bl,
                                           input bit lzb);
    int slot, phase;
    logic [7:0] h;
    logic [6:0] s7;
    slot  = (t / CD) % 4;
    phase = t % CD;
    if (bl || phase < BC) return 8'hFF;
    h  = hex_tab[(sv >> (4 * slot)) & 16'hF];
    s7 = h[6:0];
    if (lzb && slot > 0 && (sv >> (4 * slot)) == 16'h0) s7 = 7'h7F;
    return {~sd[slot], s7};
  endfunction

  task automatic model_reset();
    m_t = 0; m_shown = 16'h0; m_pend = 16'h0; m_sdp = 4'h0; m_pdp = 4'h0; m_pending = 1'b0;
  endtask

  // One clock edge: record what the edge just produced, then clear the load strobe.
  task automatic step(input bit do_rst = 1'b0);
    exp_t e;
    bit   bnd;
    @(posedge clk);
    #2;
    if (do_rst || !rst) begin
      e.seg = 8'hFF; e.seg_lz = 8'hFF; e.an = 4'hF; e.fd = 1'b0; e.pend = 1'b0;
      if (do_rst) begin
        // The edge already happened before the reset drop, so it is not checked by the monitor.
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_async_an", {28'h0, an}, 32'hF);
        check("rst_async_seg", {24'h0, seg}, 32'hFF);
        check("rst_async_fd", {31'h0, fd}, 32'h0);
        check("rst_async_pend", {31'h0, pend}, 32'h0);
      end else begin
        exp_q.push_back(e);
      end
    end else begin
      e.seg    = model_seg(m_t, m_shown, m_sdp, blank, 1'b0);
      e.seg_lz = model_seg(m_t, m_shown, m_sdp, blank, 1'b1);
      e.an     = (blank || (m_t % CD) < BC) ? 4'hF : ~(4'b0001 << ((m_t / CD) % 4));
      bnd      = (m_t % FRAME) == FRAME - 1;
      if (bnd) begin
        if (load) begin m_shown = value; m_sdp = dp; end
        else if (m_pending) begin m_shown = m_pend; m_sdp = m_pdp; end
        m_pending = 1'b0;
      end else if (load) begin
        m_pend = value; m_pdp = dp; m_pending = 1'b1;
      end
      e.fd   = bnd;
      e.pend = m_pending;
      m_t++;
      exp_q.push_back(e);
    end
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp = d;
    step();
  endtask

  task automatic wait_phase(input int ph);
    while ((m_t % FRAME) != ph) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg", {24'h0, seg}, {24'h0, e.seg});
      check("seg_lz", {24'h0, seg_lz}, {24'h0, e.seg_lz});
      check("an", {28'h0, an}, {28'h0, e.an});
      check("an_lz", {28'h0, an_lz}, {28'h0, e.an});
      check("frame_done", {31'h0, fd}, {31'h0, e.fd});
      check("frame_done_lz", {31'h0, fd_lz}, {31'h0, e.fd});
      check("pending", {31'h0, pend}, {31'h0, e.pend});
      check("pending_lz", {31'h0, pend_lz}, {31'h0, e.pend});
    end
  end

  initial begin
    model_reset();
    run(3);
    rst = 1'b1;

    // Mid-frame asynchronous reset, then restart from slot 0.
    run(7);
    step(1'b1);
    run(2);
    rst = 1'b1;

    // Scan order on a mixed-digit value.
    do_load(16'h12AF, 4'h0);
    run(2 * FRAME);

    // Double buffering: only the last mid-frame load is shown.
    wait_phase(4);
    do_load(16'h1111, 4'h0);
    run(3);
    do_load(16'h2222, 4'h0);
    run(2 * FRAME);

    // Load on the boundary cycle itself discards the older pending value.
    wait_phase(3);
    do_load(16'h3333, 4'h0);
    wait_phase(FRAME - 1);
    do_load(16'h4444, 4'h0);
    run(FRAME + 2);

    // Leading-zero patterns.
    do_load(16'h0005, 4'h0);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0);
    run(2 * FRAME);
    do_load(16'h0100, 4'h0);
    run(2 * FRAME);

    // Decimal point plus a blanking window.
    do_load(16'h8888, 4'b0100);
    run(2 * FRAME);
    wait_phase(6);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    run(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        load  = 1'b1;
        value = 16'($urandom);
        if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
        dp    = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) blank = ~blank;
      step();
    end
    blank = 1'b0;
    run(4);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Four-digit multiplexed seven-segment driver that sits downstream of the CPU core's accumulator/address outputs. It takes a 16-bit value on a load strobe and double-buffers it so frames never tear. It scans the digits using a clock prescaler and ghost-blanking, and hex-decodes each nibble to active-low segment patterns. It replaces ad-hoc display logic in the top level with one reusable sequential block.

Parameters:
CLK_DIV, 5000, clk cycles per digit slot (must be >= 2)
BLANK_CYC, 2, cycles at the start of each slot with all anodes off, for anti-ghosting (must be < CLK_DIV)
LZ_BLANK, 0, 1 = blank leading-zero digits 3..1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
load  input  1  capture value/dp this cycle
value  input  16  display value; digit0 = value[3:0] … digit3 = value[15:12]
dp  input  4  decimal point request per digit, 1 = lit
blank  input  1  1 = display dark; scanning continues
seg  output  8  active-low segments: bit7 = dp, bits6:0 = g..a (registered)
an  output  4  active-low digit enables, an[0] = digit0 (registered)
frame_done  output  1  one-cycle pulse at each frame boundary
pending  output  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Reset (rst low, asynchronous): cnt=0, idx=0, shown value/dp=0, pend register=0, pending=0, an=4'b1111, seg=8'hFF, frame_done=0. Reset mid-frame aborts the frame immediately. No partial state survives.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- Digit index: idx increments on tick and wraps 3->0. Frame boundary = tick && idx==3. frame_done is registered high for exactly the cycle after the boundary. Frame length = 4*CLK_DIV cycles.
- Load/double-buffer:
  - load in a non-boundary cycle: pend <= {value,dp}, pending <= 1. A later load overwrites an earlier one; only the last load before a boundary is ever shown.
  - At the boundary with pending=1 and no load: shown <= pend, pending <= 0.
  - load in the boundary cycle itself: shown <= input {value,dp} directly, pending <= 0. Any older pend value is discarded.
  - At the boundary with pending=0 and no load: shown is unchanged.
- Decode, 1-cycle registered latency. seg/an at cycle t+1 reflect cnt/idx/shown/blank at cycle t.
  - If blank=1 or cnt < BLANK_CYC: an=4'b1111, seg=8'hFF.
  - Otherwise: an = ~(1<<idx), seg[6:0] from nibble N=shown[4*idx+3:4*idx], seg[7] = ~dp_shown[idx].
  - Hex table (dp off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
  - LZ_BLANK=1: for idx>0, if the nibble at idx and all higher nibbles are zero, seg[6:0]=7'h7F. The dp bit still follows dp_shown, and an is still driven. Digit0 is never blanked, so 0x0000 shows "0".
- blank does not affect cnt, idx, loading, pending or frame_done.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset mid-frame: CLK_DIV=4, BLANK_CYC=1; run 7 cycles, drop rst -> an=4'b1111, seg=8'hFF, frame_done=0 immediately; after release the first slot starts at idx=0, cnt=0.
2. Scan order: CLK_DIV=4, BLANK_CYC=1; load 16'h12AF, dp=0 -> after the next frame_done, each slot is 1 cycle an=1111/seg=FF, then 3 cycles at: digit0 an=1110/seg=8E, digit1 an=1101/seg=88, digit2 an=1011/seg=A4, digit3 an=0111/seg=F9. frame_done pulses every 16 cycles.
3. Double-buffer: mid-frame load 16'h1111 then 16'h2222 -> pending=1 until the boundary; the next frame shows all digits A4; F9 never appears.
4. Boundary load: pending already holds 16'h3333; load 16'h4444 on the boundary cycle -> the frame that starts immediately shows 99 on all digits, pending=0, 3333 is never shown.
5. LZ_BLANK=1: value 16'h0005 -> digits3..1 seg=FF with their an active, digit0 seg=92. Value 16'h0000 -> digit0 seg=C0. Value 16'h0100 -> digit3 seg=FF, digit2 F9, digit1 C0, digit0 C0.
6. dp=4'b0100, value 16'h8888, then blank=1 for 20 cycles -> digit2 seg=00, other digits 80. During blank: an=1111 and seg=FF from the next cycle, frame_done keeps pulsing every 16 cycles, and scanning resumes in phase when blank drops.
